// File: rtl/fir_seq_pkg.sv
// Shared constants, state encoding and address helper for the FIR coefficient sequencer.
package fir_seq_pkg;

    localparam int unsigned NUM_MODULES  = 4;
    localparam int unsigned NUM_TAPS     = 10;
    localparam int unsigned LD_GAP_CYC   = 5;
    localparam int unsigned RD_BURST_CYC = 11;
    localparam int unsigned COEFF_W      = 16;
    localparam int unsigned NUM_WORDS    = NUM_MODULES * NUM_TAPS;
    localparam int unsigned ADDR_W       = 6;
    localparam int unsigned BURSTS_PER_ROT = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLdFlag,
        StLdData,
        StLdGap,
        StRunWait,
        StRunRd
    } state_e;

    function automatic logic [ADDR_W-1:0] coeff_addr(input logic [1:0] mod_idx,
                                                     input logic [3:0] tap);
        return ADDR_W'(mod_idx) * ADDR_W'(NUM_TAPS) + ADDR_W'(tap);
    endfunction

endpackage

// File: rtl/fir_coeff_buf.sv
// 40x16 coefficient store: one synchronous write port, one combinational read port.
module fir_coeff_buf
    import fir_seq_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [COEFF_W-1:0] rd_data
);

    logic [COEFF_W-1:0] mem [0:NUM_WORDS-1];

    // No reset: contents must survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Streams buffered FIR coefficients to the filter, then issues per-sample read bursts.
// Optional feature: define FIR_SEQ_AUTOROTATE_EN to rotate the burst module every 10 bursts.
module fir_coeff_sequencer
    import fir_seq_pkg::*;
(
    input  logic               iClk12M,
    input  logic               iRst,
    input  logic               iEnSample600k,
    input  logic               iLoadStart,
    input  logic               iHostWrEn,
    input  logic [ADDR_W-1:0]  iHostWrAddr,
    input  logic [COEFF_W-1:0] iHostWrData,
    input  logic [1:0]         iRdModuleSel,
    output logic               oCoeffUpdateFlag,
    output logic [1:0]         oModuleSel,
    output logic [COEFF_W-1:0] oWtDtRam,
    output logic               oMemRdFlag,
    output logic               oBusy,
    output logic               oLoadDone
);

    localparam logic [3:0] TapLast = 4'(NUM_TAPS - 1);
    localparam logic [3:0] GapLast = 4'(LD_GAP_CYC - 1);
    localparam logic [3:0] RdLast  = 4'(RD_BURST_CYC - 1);
    localparam logic [1:0] ModLast = 2'(NUM_MODULES - 1);

    state_e             state_q;
    logic [1:0]         module_cnt_q;
    logic [3:0]         tap_cnt_q;
    logic               upd_q;
    logic [1:0]         mod_sel_q;
    logic [COEFF_W-1:0] wt_q;
    logic               mem_rd_q;
    logic               busy_q;
    logic               load_done_q;

    logic               buf_we;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COEFF_W-1:0] rd_data;
    logic [3:0]         next_tap;
    logic [1:0]         rd_mod;
    logic               load_go;

    assign buf_we  = iHostWrEn && !busy_q && (iHostWrAddr < ADDR_W'(NUM_WORDS));
    assign load_go = iLoadStart && ((state_q == StIdle) || (state_q == StRunWait));

    // Address the tap that will be on oWtDtRam after the coming edge.
    always_comb begin
        next_tap = '0;
        if ((state_q == StLdData) && (tap_cnt_q != TapLast)) begin
            next_tap = tap_cnt_q + 4'd1;
        end
    end

    assign rd_addr = coeff_addr(module_cnt_q, next_tap);

    fir_coeff_buf u_buf (
        .clk     (iClk12M),
        .we      (buf_we),
        .wr_addr (iHostWrAddr),
        .wr_data (iHostWrData),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef FIR_SEQ_AUTOROTATE_EN
    localparam logic [3:0] RotLast = 4'(BURSTS_PER_ROT - 1);
    logic [1:0] rot_mod_q;
    logic [3:0] rot_cnt_q;
    logic       unused_rd_sel;
    assign unused_rd_sel = ^iRdModuleSel;
    assign rd_mod        = rot_mod_q;
`else
    assign rd_mod = iRdModuleSel;
`endif

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state_q      <= StIdle;
            module_cnt_q <= '0;
            tap_cnt_q    <= '0;
            upd_q        <= 1'b0;
            mod_sel_q    <= '0;
            wt_q         <= '0;
            mem_rd_q     <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b0;
`ifdef FIR_SEQ_AUTOROTATE_EN
            rot_mod_q    <= '0;
            rot_cnt_q    <= '0;
`endif
        end else begin
            load_done_q <= 1'b0;
            if (load_go) begin
                state_q      <= StLdFlag;
                module_cnt_q <= '0;
                tap_cnt_q    <= '0;
                upd_q        <= 1'b1;
                mod_sel_q    <= '0;
                wt_q         <= '0;
                busy_q       <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StRunWait: begin
                        if (iEnSample600k) begin
                            state_q   <= StRunRd;
                            tap_cnt_q <= '0;
                            mem_rd_q  <= 1'b1;
                            mod_sel_q <= rd_mod;
                        end
                    end
                    StLdFlag: begin
                        state_q   <= StLdData;
                        tap_cnt_q <= '0;
                        wt_q      <= rd_data;
                    end
                    StLdData: begin
                        if (tap_cnt_q == TapLast) begin
                            state_q   <= StLdGap;
                            tap_cnt_q <= '0;
                            upd_q     <= 1'b0;
                            wt_q      <= '0;
                        end else begin
                            tap_cnt_q <= tap_cnt_q + 4'd1;
                            wt_q      <= rd_data;
                        end
                    end
                    StLdGap: begin
                        if (tap_cnt_q == GapLast) begin
                            tap_cnt_q <= '0;
                            if (module_cnt_q == ModLast) begin
                                state_q     <= StRunWait;
                                busy_q      <= 1'b0;
                                load_done_q <= 1'b1;
`ifdef FIR_SEQ_AUTOROTATE_EN
                                rot_mod_q   <= '0;
                                rot_cnt_q   <= '0;
`endif
                            end else begin
                                state_q      <= StLdFlag;
                                module_cnt_q <= module_cnt_q + 2'd1;
                                mod_sel_q    <= module_cnt_q + 2'd1;
                                upd_q        <= 1'b1;
                            end
                        end else begin
                            tap_cnt_q <= tap_cnt_q + 4'd1;
                        end
                    end
                    StRunRd: begin
                        if (tap_cnt_q == RdLast) begin
                            state_q   <= StRunWait;
                            tap_cnt_q <= '0;
                            mem_rd_q  <= 1'b0;
`ifdef FIR_SEQ_AUTOROTATE_EN
                            if (rot_cnt_q == RotLast) begin
                                rot_cnt_q <= '0;
                                rot_mod_q <= rot_mod_q + 2'd1;
                            end else begin
                                rot_cnt_q <= rot_cnt_q + 4'd1;
                            end
`endif
                        end else begin
                            tap_cnt_q <= tap_cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign oCoeffUpdateFlag = upd_q;
    assign oModuleSel       = mod_sel_q;
    assign oWtDtRam         = wt_q;
    assign oMemRdFlag       = mem_rd_q;
    assign oBusy            = busy_q;
    assign oLoadDone        = load_done_q;

endmodule
